// File: rtl/dm_lsu_pkg.sv
// rtl/dm_lsu_pkg.sv - shared encodings and alignment check for the load/store unit
package dm_lsu_pkg;

    // Access size encodings as presented on the size port.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // An access is rejected when its size is illegal or its address is not
    // naturally aligned to that size.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lsb[0];
            SZ_WORD: bad = (lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// rtl/dm_lane.sv - byte/halfword lane extract, extend and merge
//
// Purely combinational. Ports:
//   word       memory word being read (load) or modified (sub-word store)
//   size       access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   offset     byte offset within the word, little-endian lanes
//   sext       1 = sign-extend the extracted lane, 0 = zero-extend
//   store_data right-justified store data
//   load_data  extracted and extended lane (whole word for SZ_WORD)
//   merged     word with the target lane replaced (store_data for SZ_WORD)
module dm_lane
    import dm_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sext,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[{offset, 3'b000} +: 8];
        lane_half = offset[1] ? word[31:16] : word[15:0];
        load_data = word;
        merged    = store_data;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sext & lane_byte[7]}}, lane_byte};
                merged    = word;
                merged[{offset, 3'b000} +: 8] = store_data[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sext & lane_half[15]}}, lane_half};
                merged    = word;
                merged[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            end
            default: begin
                load_data = word;
                merged    = store_data;
            end
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - load/store unit in front of the word-wide data memory
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req/wr/size/sext   request strobe and attributes, sampled only while ready
//   addr, wdata        byte address and right-justified store data
//   ready              unit idle; a request presented now is accepted
//   done, err          one-cycle completion pulse and its error flag
//   rdata              last successful load result
//   dm_addr/dm_din/dm_we  word address, write data and write enable to memory
//   dm_dout            combinational read data from memory
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int ADDR_LSB = 2,
    parameter int ADDR_MSB = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic                         wr,
    input  logic [1:0]                   size,
    input  logic                         sext,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  wdata,
    output logic                         ready,
    output logic                         done,
    output logic                         err,
    output logic [31:0]                  rdata,
    output logic [ADDR_MSB-ADDR_LSB:0]   dm_addr,
    output logic [31:0]                  dm_din,
    output logic                         dm_we,
    input  logic [31:0]                  dm_dout
);

    state_t              state_q, state_d;
    logic                wr_q;
    logic [1:0]          size_q;
    logic                sext_q;
    logic [ADDR_MSB:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic [31:0]         word_q;

    logic [31:0]         lane_word;
    logic [31:0]         load_data;
    logic [31:0]         merged;
    logic                accept;
    logic                unused_addr_hi;

    // Address bits above the memory window play no part in the access.
    assign unused_addr_hi = ^addr[31:ADDR_MSB+1];

    assign accept = (state_q == ST_IDLE) && req;

    // In READ the lane logic looks straight at the memory port so the load
    // result is registered in the same edge that captures the word; in WRITE
    // it works on the captured word to build the merged store word.
    assign lane_word = (state_q == ST_READ) ? dm_dout : word_q;

    dm_lane u_lane (
        .word       (lane_word),
        .size       (size_q),
        .offset     (addr_q[1:0]),
        .sext       (sext_q),
        .store_data (wdata_q),
        .load_data  (load_data),
        .merged     (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        dm_we   = 1'b0;
        dm_din  = 32'h0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    if (access_err(size, addr[1:0])) begin
                        state_d = ST_RESP;
                    end else if (!wr || (size != SZ_WORD)) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                state_d = wr_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                dm_we   = 1'b1;
                dm_din  = merged;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The address is driven from the latched request in every state so it
    // never follows req directly.
    assign dm_addr = addr_q[ADDR_MSB:ADDR_LSB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            word_q  <= 32'h0;
            rdata   <= 32'h0;
        end else begin
            if (accept) begin
                wr_q    <= wr;
                size_q  <= size;
                sext_q  <= sext;
                addr_q  <= addr[ADDR_MSB:0];
                wdata_q <= wdata;
                err_q   <= access_err(size, addr[1:0]);
            end
            if (state_q == ST_READ) begin
                word_q <= dm_dout;
                if (!wr_q) begin
                    rdata <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - directed self-checking bench for dm_lsu
module tb_dm_lsu;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    logic [31:0] mem [0:1023];
    int          we_count;
    int          n_checks;
    int          n_errors;

    dm_lsu #(.ADDR_LSB(2), .ADDR_MSB(11)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .sext    (sext),
        .addr    (addr),
        .wdata   (wdata),
        .ready   (ready),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .dm_addr (dm_addr),
        .dm_din  (dm_din),
        .dm_we   (dm_we),
        .dm_dout (dm_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_addr] <= dm_din;
            we_count = we_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present one request at a negedge, release req after the accept edge and
    // report the number of cycles until done (0 if it never came).
    task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic e);
        @(negedge clk);
        check("ready_before_req", {31'h0, ready}, 32'h1);
        req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        e   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                e   = err;
                break;
            end
        end
        @(negedge clk);
        check("done_one_cycle", {31'h0, done}, 32'h0);
    endtask

    int          lat;
    logic        e;
    int          we0;
    logic [31:0] rd0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;

    op_t ops [4];
    int  k;
    int  dones;
    int  done_cycle;

    initial begin
        n_checks = 0;
        n_errors = 0;
        we_count = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4] = 32'hCAFEF00D;
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0;
        addr = 32'h0; wdata = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_ready",   {31'h0, ready}, 32'h1);
        check("rst_done",    {31'h0, done},  32'h0);
        check("rst_err",     {31'h0, err},   32'h0);
        check("rst_rdata",   rdata,          32'h0);
        check("rst_dm_we",   {31'h0, dm_we}, 32'h0);
        check("rst_dm_din",  dm_din,         32'h0);
        check("rst_dm_addr", {22'h0, dm_addr}, 32'h0);
        rst = 1'b0;

        // Reset during the WRITE cycle of a word store must not commit it.
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h010; wdata = 32'h11223344;
        @(posedge clk);
        #1 req = 1'b0;
        check("midw_we_high", {31'h0, dm_we}, 32'h1);
        check("midw_addr",    {22'h0, dm_addr}, 32'h4);
        check("midw_din",     dm_din, 32'h11223344);
        #1 rst = 1'b1;
        #1;
        check("midw_we_drop", {31'h0, dm_we}, 32'h0);
        check("midw_ready",   {31'h0, ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midw_done",    {31'h0, done}, 32'h0);
        check("midw_mem4",    mem[4], 32'hCAFEF00D);
        check("midw_rdata",   rdata, 32'h0);
        check("midw_we_cnt",  we_count, 0);

        // Word store then word load.
        we0 = we_count;
        do_op(1'b1, 2'b10, 1'b0, 32'h020, 32'hDEADBEEF, lat, e);
        check("sw_lat",   lat, 2);
        check("sw_err",   {31'h0, e}, 32'h0);
        check("sw_we",    we_count - we0, 1);
        check("sw_mem8",  mem[8], 32'hDEADBEEF);
        we0 = we_count;
        do_op(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, lat, e);
        check("lw_lat",   lat, 2);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_we",    we_count - we0, 0);

        // Byte store: upper bits of wdata must be ignored.
        we0 = we_count;
        do_op(1'b1, 2'b00, 1'b0, 32'h021, 32'hAAAAAA55, lat, e);
        check("sb_lat",   lat, 3);
        check("sb_we",    we_count - we0, 1);
        check("sb_mem8",  mem[8], 32'hDEAD55EF);
        check("sb_rdata", rdata, 32'hDEADBEEF);

        // Sub-word loads with both extensions; address high bits ignored.
        do_op(1'b0, 2'b00, 1'b1, 32'h023, 32'h0, lat, e);
        check("lb_lat",   lat, 2);
        check("lb_rdata", rdata, 32'hFFFFFFDE);
        do_op(1'b0, 2'b00, 1'b0, 32'hF000_1023, 32'h0, lat, e);
        check("lbu_rdata", rdata, 32'h000000DE);
        do_op(1'b0, 2'b01, 1'b1, 32'h022, 32'h0, lat, e);
        check("lh_rdata",  rdata, 32'hFFFFDEAD);
        do_op(1'b0, 2'b01, 1'b1, 32'h020, 32'h0, lat, e);
        check("lh_pos_rdata", rdata, 32'h000055EF);
        do_op(1'b0, 2'b00, 1'b1, 32'h020, 32'h0, lat, e);
        check("lb0_rdata", rdata, 32'hFFFFFFEF);

        // Halfword store to the upper lane.
        do_op(1'b1, 2'b01, 1'b0, 32'h022, 32'h00001234, lat, e);
        check("sh_lat",  lat, 3);
        check("sh_mem8", mem[8], 32'h123455EF);

        // Error cases: done+err one cycle after accept, no write, rdata held.
        rd0 = rdata;
        we0 = we_count;
        do_op(1'b0, 2'b10, 1'b0, 32'h022, 32'h0, lat, e);
        check("lw_mis_lat", lat, 1);
        check("lw_mis_err", {31'h0, e}, 32'h1);
        do_op(1'b1, 2'b01, 1'b0, 32'h021, 32'hFFFF, lat, e);
        check("sh_mis_lat", lat, 1);
        check("sh_mis_err", {31'h0, e}, 32'h1);
        do_op(1'b0, 2'b11, 1'b1, 32'h000, 32'h0, lat, e);
        check("ill_lat", lat, 1);
        check("ill_err", {31'h0, e}, 32'h1);
        check("err_we",    we_count - we0, 0);
        check("err_rdata", rdata, rd0);
        check("err_mem8",  mem[8], 32'h123455EF);

        // req held high with alternating sw/lw: one accept per IDLE cycle.
        ops[0] = '{1'b1, 32'h030, 32'hA5A5_0001};
        ops[1] = '{1'b0, 32'h030, 32'h0};
        ops[2] = '{1'b1, 32'h034, 32'h5A5A_0002};
        ops[3] = '{1'b0, 32'h034, 32'h0};
        we0 = we_count;
        k = 0;
        dones = 0;
        done_cycle = -1;
        size = 2'b10;
        sext = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (dones == 4) begin
                    done_cycle = c;
                    break;
                end
            end
            if (ready) begin
                if (k < 4) begin
                    req = 1'b1; wr = ops[k].w; addr = ops[k].a; wdata = ops[k].d;
                    k++;
                end else begin
                    req = 1'b0;
                end
            end
        end
        req = 1'b0;
        check("stream_dones", dones, 4);
        check("stream_cycle", done_cycle, 11);
        check("stream_we",    we_count - we0, 2);
        check("stream_mem12", mem[12], 32'hA5A5_0001);
        check("stream_mem13", mem[13], 32'h5A5A_0002);
        check("stream_rdata", rdata,   32'h5A5A_0002);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
